// File: rtl/poly_arith_pkg.sv
// Shared types and constants for the ML-KEM polynomial arithmetic blocks.
//   coeff_t         : 12-bit coefficient, reduced values lie in [0, Q-1]
//   Q               : ML-KEM modulus 3329
//   N_COEFFS        : coefficients per polynomial
//   addsub_state_e  : state encoding of the poly add/sub sequencer
//   neg_mod_q()     : additive inverse mod Q of a reduced coefficient
package poly_arith_pkg;

  typedef logic [11:0] coeff_t;

  localparam coeff_t Q        = 12'd3329;
  localparam int     N_COEFFS = 256;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } addsub_state_e;

  // Q - b would give Q (not reduced) for b == 0, so zero maps to zero.
  function automatic coeff_t neg_mod_q(input coeff_t b);
    return (b == '0) ? '0 : coeff_t'(Q - b);
  endfunction

endpackage

// File: rtl/mod_add.sv
// Two-stage pipelined modular adder: result = (op1 + op2) mod Q.
//   clk      : clock
//   rst      : synchronous active-high reset, clears the pipeline
//   op1_i    : first operand, in [0, Q-1]
//   op2_i    : second operand, in [0, Q-1]
//   valid_i  : operand pair is valid this cycle
//   result_o : reduced sum, holds its value between valid results
//   valid_o  : result_o is valid, two cycles after valid_i
module mod_add
  import poly_arith_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  coeff_t op1_i,
  input  coeff_t op2_i,
  input  logic   valid_i,
  output coeff_t result_o,
  output logic   valid_o
);

  logic        s1_valid;
  logic [12:0] s1_sum;
  coeff_t      s1_reduced;

  // The raw sum is below 2Q, so one conditional subtraction reduces it.
  // Subtracting in 12 bits is exact because the true difference is < Q.
  always_comb begin
    s1_reduced = s1_sum[11:0];
    if (s1_sum >= {1'b0, Q}) begin
      s1_reduced = s1_sum[11:0] - Q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_sum <= {1'b0, op1_i} + {1'b0, op2_i};
      end
      valid_o <= s1_valid;
      if (s1_valid) begin
        result_o <= s1_reduced;
      end
    end
  end

endmodule

// File: rtl/poly_addsub_engine.sv
// Polynomial-level add/sub sequencer for ML-KEM: streams a[i], b[i] from the
// poly RAM through mod_add and writes c[i] = a[i] +/- b[i] mod Q back.
//   clk, rst_n    : clock, synchronous active-low reset
//   start_i       : start request, only looked at in IDLE
//   sub_i         : 0 = add, 1 = subtract, latched on start accept
//   busy_o        : high from the cycle after start accept through done
//   done_o        : one-cycle pulse once the last result is written
//   rd_en_o       : read strobe, N consecutive cycles per run
//   rd_addr_o     : read address shared by the a and b ports
//   rd_a_data_i   : a[rd_addr], one cycle after rd_en_o
//   rd_b_data_i   : b[rd_addr], one cycle after rd_en_o
//   wr_en_o       : result write strobe
//   wr_addr_o     : result address
//   wr_data_o     : result coefficient, holds when wr_en_o is low
//   dbg_state_o   : current FSM state
//
// Handshake: there is no backpressure on either side. rd_en_o is a one-way
// request and data is assumed one cycle later; wr_en_o is a one-way write
// that the RAM must take in that cycle.
module poly_addsub_engine
  import poly_arith_pkg::*;
#(
  parameter int N      = N_COEFFS,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              sub_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  input  coeff_t            rd_a_data_i,
  input  coeff_t            rd_b_data_i,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] wr_addr_o,
  output coeff_t            wr_data_o,
  output addsub_state_e     dbg_state_o
);

  // One extra counter bit lets the counters reach N = 2^ADDR_W directly.
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] CNT_LAST = (ADDR_W+1)'(N - 1);
  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(N);

  addsub_state_e   state, state_nxt;
  logic [ADDR_W:0] rd_cnt;
  logic [ADDR_W:0] wr_cnt, wr_cnt_nxt;
  logic            sub_r;
  logic            op_valid;
  coeff_t          op2;
  coeff_t          add_result;
  logic            add_valid;
  logic            wr_fire;
  logic            start_accept;

  assign start_accept = (state == ST_IDLE) && start_i;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DRAIN leaves on the edge that commits the last write, so DONE lands in
  // the cycle right after it.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_i) state_nxt = ST_ISSUE;
      ST_ISSUE: if (rd_cnt == CNT_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN: if (wr_cnt_nxt == CNT_FULL) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy_o      = (state != ST_IDLE);
  assign done_o      = (state == ST_DONE);
  assign rd_en_o     = (state == ST_ISSUE);
  assign rd_addr_o   = rd_cnt[ADDR_W-1:0];
  assign dbg_state_o = state;

  // ---------------- counters and operation latch ----------------
  // Results beyond N are dropped rather than written past the polynomial.
  assign wr_fire    = add_valid && (wr_cnt < CNT_FULL);
  assign wr_cnt_nxt = wr_fire ? (wr_cnt + CNT_ONE) : wr_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      sub_r    <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      // Operands arrive one cycle after the read strobe.
      op_valid <= rd_en_o;
      if (start_accept) begin
        sub_r  <= sub_i;
        rd_cnt <= '0;
        wr_cnt <= '0;
      end else begin
        if (rd_en_o) begin
          rd_cnt <= rd_cnt + CNT_ONE;
        end
        wr_cnt <= wr_cnt_nxt;
      end
    end
  end

  // ---------------- operand and result paths ----------------
  assign op2 = sub_r ? neg_mod_q(rd_b_data_i) : rd_b_data_i;

  mod_add u_mod_add (
    .clk      (clk),
    .rst      (~rst_n),
    .op1_i    (rd_a_data_i),
    .op2_i    (op2),
    .valid_i  (op_valid),
    .result_o (add_result),
    .valid_o  (add_valid)
  );

  // Results come back in issue order, so the write counter alone gives the
  // address regardless of the adder's latency.
  assign wr_en_o   = wr_fire;
  assign wr_addr_o = wr_cnt[ADDR_W-1:0];
  assign wr_data_o = add_result;

  a_no_extra_result : assert property (
    @(posedge clk) disable iff (!rst_n) !(add_valid && (wr_cnt >= CNT_FULL))
  );

endmodule

// File: doc/poly_addsub_engine.md
Name: poly_addsub_engine

Overview:
- Sequencer that drives the coefficient-stream side of the existing mod_add unit. It reads two length-N polynomials (a, b) from a coefficient RAM read port and issues one coefficient pair per cycle with op1_i/op2_i/valid_i.
- It collects result_o/valid_o and writes c = a+b or c = a−b (mod Q) back through a RAM write port.
- It is the polynomial-level add/sub engine for ML-KEM (FIPS 203, Q = 3329), and sits between the poly RAM and mod_add.

Parameters:
N, 256, coefficients per polynomial
ADDR_W, 8, coefficient address width (N ≤ 2^ADDR_W)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  start request; sampled only in IDLE
sub_i  in  1  0 = add, 1 = subtract; latched when start is accepted
busy_o  out  1  high from start accept through the done cycle
done_o  out  1  one-cycle pulse when the last result has been written
rd_en_o  out  1  read strobe to the a/b RAM ports
rd_addr_o  out  ADDR_W  read address; same address on both ports
rd_a_data_i  in  12 (coeff_t)  a[rd_addr], valid 1 cycle after rd_en_o
rd_b_data_i  in  12 (coeff_t)  b[rd_addr], valid 1 cycle after rd_en_o
wr_en_o  out  1  result write strobe
wr_addr_o  out  ADDR_W  result address
wr_data_o  out  12 (coeff_t)  result coefficient, in [0, Q−1]

Behaviour:
- Reset (rst_n = 0 at a clk edge):
  - FSM goes to IDLE; read and write counters clear to 0.
  - All outputs are 0: busy_o, done_o, rd_en_o, rd_addr_o, wr_en_o, wr_addr_o, wr_data_o.
  - The mod_add instance is reset via its active-high rst = ~rst_n, so in-flight pipeline data is discarded.
- FSM states: IDLE → ISSUE → DRAIN → DONE → IDLE.
  - IDLE: if start_i = 1, latch sub_i, clear counters, go to ISSUE.
  - ISSUE:
    - rd_en_o = 1 with rd_addr_o = read counter; the read counter increments every cycle.
    - After issuing address N−1, go to DRAIN.
    - No gaps and no stalls: exactly N consecutive read cycles.
  - DRAIN: rd_en_o = 0; wait until the write counter reaches N, then go to DONE.
  - DONE: done_o = 1 for exactly one cycle; return to IDLE.
- start_i is ignored in ISSUE, DRAIN and DONE. It is accepted again in IDLE, at the earliest one cycle after done_o.
- Operand path:
  - mod_add valid_i = rd_en_o delayed 1 cycle (matches the RAM read latency).
  - op1_i = rd_a_data_i.
  - op2_i = rd_b_data_i when adding. When subtracting, op2_i = (b == 0) ? 0 : Q − b; this negation is combinational, 12-bit, never negative.
- Result path:
  - On each mod_add valid_o: wr_en_o = 1, wr_data_o = result_o, wr_addr_o = write counter; the write counter then increments.
  - Results return in issue order, so this path does not depend on mod_add latency.
  - wr_data_o holds its last value when wr_en_o = 0.
- Latency, with mod_add latency 2 and the start-accept cycle as cycle 0:
  - rd_en_o is high in cycles 1..N.
  - wr_en_o is high in cycles 4..N+3.
  - done_o is high in cycle N+4 (260 for N = 256).
  - busy_o is high in cycles 1..N+4.
- Input range: a and b are required in [0, Q−1]; outputs are unspecified otherwise.
- Counters are ADDR_W+1 bits wide, so reaching N = 2^ADDR_W needs no wrap special case. rd_addr_o and wr_addr_o are the low ADDR_W bits.
- Write count check: if valid_o is seen after N writes, that result is dropped (no wr_en_o) and a simulation assertion fires.
- Reset mid-operation: the FSM aborts to IDLE on the same edge; no further wr_en_o; done_o is not asserted.

Decomposition:
- poly_arith_pkg: coeff_t (12-bit) and Q = 3329 are already there. Add N_COEFFS = 256 and a state enum type for this FSM.
- One sub-module: the existing mod_add, instantiated unchanged. The negation mux and FSM stay in poly_addsub_engine.

Test Plan:
- Add, a[i] = i, b[i] = 20 → wr_data[i] = (i+20) mod 3329 at wr_addr i. 256 writes in cycles 4..259; done_o only in cycle 260.
- Add wrap, a = 3328, b = 1 everywhere → all results 0. Also a = b = 3328 → all results 3327.
- Subtract, a = 0, b = 1 → 3328. a = 5, b = 0 → 5. a = 3000, b = 3000 → 0. a = 10, b = 3328 → 11.
- start_i held high through the whole run with sub_i toggling → exactly one run, op from the start-accept cycle. A second run starts in the first IDLE cycle after done_o and repeats the same timing.
- rst_n = 0 for one cycle at cycle 100 of a run → all outputs 0 the next cycle, no writes after that, no done_o. A new start completes normally with correct results.
- Back-to-back runs (add then sub) on random reduced inputs → every write is checked against a golden (a ± b) mod Q model in address order: N writes per run, no duplicate or missing addresses.
